seq_mult: RTL and testbench

Parametrised sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH. It is the clocked successor of the team's 2x2 gate-level combinational multiplier netlists.
- Adds signed/unsigned mode selection per operation.
- Adds valid/ready handshakes on input and output.
- Has fixed, data-independent latency, so timing paths are deterministic for STA test cases.

---
 rtl/mult_pkg.sv | 7 +
 rtl/mult_pp_addsub.sv | 12 +
 rtl/seq_mult.sv | 76 +++++++
 tb/tb_seq_mult.sv | 115 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and counter sizing for the sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/mult_pp_addsub.sv
// mult_pp_addsub: conditional add/subtract of a shifted partial product into the accumulator
module mult_pp_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] pp,
  input  logic         sub,
  input  logic         en,
  output logic [W-1:0] sum
);
  always_comb sum = !en ? acc : sub ? acc - pp : acc + pp;
endmodule

// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add multiplier, signed/unsigned, fixed WIDTH-cycle latency
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               SGN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] M
);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              sgn_q, ov_q, last;
  logic [PW-1:0]     acc_q, acc_d, m_q, a_ext, pp;
  logic [CW-1:0]     cnt_q;
  assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign pp = a_ext << cnt_q;
  assign last = cnt_q == CW'(WIDTH - 1);
  // the multiplier MSB carries negative weight in two's complement
  mult_pp_addsub #(.W(PW)) u_addsub (
    .acc(acc_q),
    .pp (pp),
    .sub(sgn_q & last),
    .en (b_q[cnt_q]),
    .sum(acc_d)
  );
  assign IN_READY = (state_q == IDLE) & ~RST;
  assign OUT_VALID = ov_q;
  assign M = m_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      m_q <= '0;
      ov_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (IN_VALID) begin
          a_q <= A;
          b_q <= B;
          sgn_q <= SGN;
          acc_q <= '0;
          cnt_q <= '0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            m_q <= acc_d;
            ov_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: if (OUT_READY) begin
          ov_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed and randomised checks of seq_mult at WIDTH=4
module tb_seq_mult;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, sgn = 1'b0;
  logic       out_valid, out_ready = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [7:0] m, m_hold;
  int         n_cmp = 0, n_err = 0, lat;
  seq_mult #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .SGN(sgn), .OUT_VALID(out_valid), .OUT_READY(out_ready), .M(m)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y, input logic s);
    int p;
    p = (s ? int'($signed(x)) : int'(x)) * (s ? int'($signed(y)) : int'(y));
    return 8'(p);
  endfunction
  task automatic start(input logic [3:0] x, input logic [3:0] y, input logic s);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; sgn = s;
    chk("ready_at_offer", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom_range(0, 15); b = $urandom_range(0, 15); sgn = $urandom_range(0, 1);
  endtask
  task automatic wait_res(input string tag, input logic [7:0] exp);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_m"}, m, exp);
  endtask
  task automatic drain(input int stall);
    m_hold = m;
    repeat (stall) begin
      @(negedge clk);
      if (m !== m_hold || !out_valid || in_ready) chk("hold_stable", {m, out_valid, in_ready}, {m_hold, 2'b10});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_drop", out_valid, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    chk("rst_m", m, 8'h00);
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_rdy", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("idle_rdy", in_ready, 1);
    chk("idle_ov", out_valid, 0);
    start(4'd3, 4'd3, 0);   wait_res("u3x3", 8'd9);   drain(0);
    start(4'd15, 4'd15, 0); wait_res("uFxF", 8'hE1);
    in_valid = 1'b1; a = 4'd2; b = 4'd5; sgn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ov", out_valid, 1);
      chk("bp_m", m, 8'hE1);
      chk("bp_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_rdy", in_ready, 1);
    chk("bp_idle_ov", out_valid, 0);
    chk("bp_m_kept", m, 8'hE1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_taken", in_ready, 0);
    wait_res("bp_new", 8'd10); drain(1);
    start(4'hD, 4'h5, 1); wait_res("sDx5", 8'hF1); drain(2);
    start(4'h8, 4'h8, 1); wait_res("s8x8", 8'h40); drain(0);
    start(4'h7, 4'hF, 1); wait_res("s7xF", 8'hF9); drain(0);
    start(4'd9, 4'd9, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_m", m, 8'h00);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) chk("no_stale_ov", out_valid, 0);
    end
    start(4'd6, 4'd7, 0); wait_res("u6x7", 8'd42); drain(0);
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] x, y;
      logic s;
      x = $urandom_range(0, 15); y = $urandom_range(0, 15); s = $urandom_range(0, 1);
      start(x, y, s);
      wait_res("rand", ref_mul(x, y, s));
      drain($urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
